// File: rtl/cs_window_filter.sv
// cs_window_filter: sliding-window approximate-average filter.
// Stage 1 holds window/sum; stage 2 picks avg or appr and scales.
module cs_window_filter #(
  parameter int DW    = 8,
  parameter int WIN   = 9,
  parameter int SHIFT = 3,
  parameter int OW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] X,
  input  logic          mode,
  input  logic          flush,
  output logic          out_valid,
  output logic [OW-1:0] Y
);

  localparam int SW = DW + $clog2(WIN);
  localparam int TW = DW + $clog2(2 * WIN);
  localparam int CW = $clog2(WIN + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] WIN_S    = SW'(WIN);
  localparam logic [TW-1:0] WIN_T    = TW'(WIN);

  logic [DW-1:0] win_q [WIN];
  logic [SW-1:0] sum_q;
  logic [CW-1:0] cnt_q;
  logic          s1_valid_q;

  logic [DW-1:0] oldest;
  logic [SW-1:0] sum_base;
  logic [SW-1:0] sum_d;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_d;

  // Flush restarts the window, so the new sample sees an empty history.
  always_comb begin
    oldest   = '0;
    sum_base = sum_q;
    cnt_base = cnt_q;
    if (flush) begin
      sum_base = '0;
      cnt_base = '0;
    end else if (cnt_q == CNT_FULL) begin
      oldest = win_q[WIN-1];
    end
    sum_d = sum_base + SW'(X) - SW'(oldest);
    if (cnt_base == CNT_FULL) begin
      cnt_d = CNT_FULL;
    end else begin
      cnt_d = cnt_base + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
      sum_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid && (cnt_d == CNT_FULL);
      if (in_valid) begin
        win_q[0] <= X;
        for (int i = 1; i < WIN; i++) begin
          win_q[i] <= flush ? '0 : win_q[i-1];
        end
        sum_q <= sum_d;
        cnt_q <= cnt_d;
      end else if (flush) begin
        for (int i = 0; i < WIN; i++) begin
          win_q[i] <= '0;
        end
        sum_q <= '0;
        cnt_q <= '0;
      end
    end
  end

  logic [SW-1:0] avg;
  logic [DW-1:0] avg_dw;
  logic [DW-1:0] appr;
  logic [DW-1:0] sel;
  logic [TW-1:0] tmp;
  logic [TW-1:0] shifted;

  // appr always exists: the window minimum never exceeds the mean.
  always_comb begin
    avg    = sum_q / WIN_S;
    avg_dw = DW'(avg);
    appr   = '0;
    for (int i = 0; i < WIN; i++) begin
      if (SW'(win_q[i]) <= avg && win_q[i] >= appr) begin
        appr = win_q[i];
      end
    end
    sel     = mode ? avg_dw : appr;
    tmp     = TW'(sum_q) + WIN_T * TW'(sel);
    shifted = tmp >> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Y         <= '0;
    end else begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        Y <= OW'(shifted);
      end
    end
  end

endmodule

// File: tb/tb_cs_window_filter.sv
// tb_cs_window_filter: directed and random checks of four filter
// configurations against a queue-based reference model.
module tb_cs_window_filter;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       mode;
  logic       flush;
  logic [7:0] X;
  logic       ov [NI];
  logic [9:0] yv [NI];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  cs_window_filter #(.DW(8), .WIN(9), .SHIFT(3), .OW(10)) u_w9 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .mode(mode), .flush(flush), .out_valid(ov[0]), .Y(yv[0]));

  cs_window_filter #(.DW(8), .WIN(4), .SHIFT(2), .OW(10)) u_w4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .mode(mode), .flush(flush), .out_valid(ov[1]), .Y(yv[1]));

  cs_window_filter #(.DW(8), .WIN(2), .SHIFT(1), .OW(10)) u_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .mode(mode), .flush(flush), .out_valid(ov[2]), .Y(yv[2]));

  cs_window_filter #(.DW(8), .WIN(16), .SHIFT(3), .OW(10)) u_w16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .mode(mode), .flush(flush), .out_valid(ov[3]), .Y(yv[3]));

  function automatic int win_of(input int k);
    return (k == 0) ? 9 : (k == 1) ? 4 : (k == 2) ? 2 : 16;
  endfunction

  function automatic int sh_of(input int k);
    return (k == 0) ? 3 : (k == 1) ? 2 : (k == 2) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
    end
  endtask

  // Reference model: accepted samples since reset/flush.
  int hist [$];
  bit pv [NI];
  int ps [NI];
  int pa [NI];
  int pp [NI];
  bit ev [NI];
  int ey [NI];
  int m_n, m_w, m_s, m_a, m_p;

  always @(posedge clk) begin
    if (!reset) begin
      hist.delete();
      for (int k = 0; k < NI; k++) begin
        pv[k] = 1'b0;
        ev[k] = 1'b0;
        ey[k] = 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        ev[k] = pv[k];
        if (pv[k])
          ey[k] = ((ps[k] + win_of(k) * (mode ? pa[k] : pp[k]))
                   >> sh_of(k)) % 1024;
      end
      if (flush) hist.delete();
      if (in_valid) begin
        hist.push_back(int'(X));
        if (hist.size() > 16) void'(hist.pop_front());
      end
      for (int k = 0; k < NI; k++) begin
        m_w   = win_of(k);
        m_n   = hist.size();
        pv[k] = in_valid && (m_n >= m_w);
        if (pv[k]) begin
          m_s = 0;
          for (int j = m_n - m_w; j < m_n; j++) m_s += hist[j];
          m_a = m_s / m_w;
          m_p = 0;
          for (int j = m_n - m_w; j < m_n; j++)
            if (hist[j] <= m_a && hist[j] > m_p) m_p = hist[j];
          ps[k] = m_s;
          pa[k] = m_a;
          pp[k] = m_p;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("mdl_ov%0d", k), 32'(ov[k]), 32'(ev[k]));
        chk($sformatf("mdl_y%0d", k), 32'(yv[k]), 32'(ey[k]));
      end
    end
  end

  task automatic push(input int x, input bit m = 1'b0,
                      input bit f = 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    X        = 8'(x);
    mode     = m;
    flush    = f;
  endtask

  task automatic idle(input bit m = 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    mode     = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    mode     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int hits;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    flush    = 1'b0;
    X        = '0;
    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(ov[0]), 32'd0);
    chk("rst_y", 32'(yv[0]), 32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    for (int i = 1; i <= 9; i++) push(i);
    push(10);
    chk("fill_early", 32'(ov[0]), 32'd0);
    idle();
    chk("fill_ov", 32'(ov[0]), 32'd1);
    chk("fill_y", 32'(yv[0]), 32'd11);
    @(negedge clk);
    chk("next_ov", 32'(ov[0]), 32'd1);
    chk("next_y", 32'(yv[0]), 32'd13);
    @(negedge clk);
    chk("drop_ov", 32'(ov[0]), 32'd0);
    chk("hold_y", 32'(yv[0]), 32'd13);

    do_reset();
    repeat (9) push(255);
    idle();
    idle();
    chk("full_ov", 32'(ov[0]), 32'd1);
    chk("full_y", 32'(yv[0]), 32'd573);

    do_reset();
    repeat (8) push(0);
    push(90);
    idle(1'b0);
    idle(1'b0);
    chk("appr_y", 32'(yv[0]), 32'd11);
    do_reset();
    repeat (8) push(0);
    push(90);
    idle(1'b1);
    idle(1'b1);
    chk("exact_y", 32'(yv[0]), 32'd22);

    do_reset();
    push(2); push(4); push(6); push(8);
    idle();
    idle();
    chk("w4_ov", 32'(ov[1]), 32'd1);
    chk("w4_y", 32'(yv[1]), 32'd9);

    do_reset();
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      push(int'($urandom_range(0, 255)));
      idle();
      hits += int'(ov[0]);
    end
    push(7, 1'b0, 1'b1);
    hits += int'(ov[0]);
    repeat (8) begin
      push(7);
      hits += int'(ov[0]);
    end
    chk("gap_noout", 32'(hits), 32'd0);
    idle();
    idle();
    chk("flush_ov", 32'(ov[0]), 32'd1);
    chk("flush_y", 32'(yv[0]), 32'd15);
    idle();
    chk("flush_once", 32'(ov[0]), 32'd0);

    do_reset();
    for (int i = 1; i <= 9; i++) push(i);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_ov", 32'(ov[0]), 32'd0);
    chk("midrst_y", 32'(yv[0]), 32'd0);
    hits = 0;
    repeat (8) begin
      push(3);
      hits += int'(ov[0]);
    end
    push(3);
    hits += int'(ov[0]);
    idle();
    hits += int'(ov[0]);
    chk("midrst_quiet", 32'(hits), 32'd0);
    idle();
    chk("midrst_back", 32'(ov[0]), 32'd1);
    chk("midrst_y2", 32'(yv[0]), 32'd6);

    repeat (3000) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 199) != 0);
      in_valid = ($urandom_range(0, 9) < 7);
      X        = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                             : 8'($urandom_range(0, 255));
      mode     = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 49) == 0);
    end

    reset = 1'b1;
    idle();
    idle();
    idle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
